uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller that strobes bits into a downstream SIPO.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic rx_clk,
  input  logic rx_rst_n,
  input  logic rx_in,
  input  logic sample_tick,
  output logic shift,
  output logic serial_bit,
  output logic load,
  output logic frame_err,
  output logic parity_err,
  output logic busy
);
  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge on rx_s
  // START  | confirming the start bit at its centre
  // DATA   | sampling DATA_WIDTH bits at bit centres, LSB first
  // PARITY | sampling the even-parity bit (UART_PARITY_EN only)
  // STOP   | sampling the stop bit, issuing load or error strobes

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_CNT   = BW'(DATA_WIDTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            rx_meta_q, rx_s_q;
  logic            need_high_q, need_high_d;
  logic            shift_q, shift_d;
  logic            bit_val_q, bit_val_d;
  logic            load_q, load_d;
  logic            ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic            par_q, par_d;
  logic            par_bad_q, par_bad_d;
  logic            perr_q, perr_d;
`endif

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      need_high_q <= 1'b0;
      shift_q     <= 1'b0;
      bit_val_q   <= 1'b0;
      load_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_PARITY_EN
      par_q       <= 1'b0;
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      need_high_q <= need_high_d;
      shift_q     <= shift_d;
      bit_val_q   <= bit_val_d;
      load_q      <= load_d;
      ferr_q      <= ferr_d;
`ifdef UART_PARITY_EN
      par_q       <= par_d;
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    need_high_d = need_high_q;
    shift_d     = 1'b0;
    bit_val_d   = bit_val_q;
    load_d      = 1'b0;
    ferr_d      = 1'b0;
`ifdef UART_PARITY_EN
    par_d       = par_q;
    par_bad_d   = par_bad_q;
    perr_d      = 1'b0;
`endif

    // After a low stop bit the line must be seen high before a new start is accepted.
    if (need_high_q && rx_s_q) need_high_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q && !need_high_q) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
`ifdef UART_PARITY_EN
          par_d     = 1'b0;
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_FULL) begin
            tick_d    = '0;
            shift_d   = 1'b1;
            bit_val_d = rx_s_q;
            bit_d     = bit_q + BW'(1);
`ifdef UART_PARITY_EN
            par_d = par_q ^ rx_s_q;
            if (bit_d == BIT_CNT) state_d = PARITY;
`else
            if (bit_d == BIT_CNT) state_d = STOP;
`endif
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          if (tick_q == TICK_FULL) begin
            tick_d    = '0;
            par_bad_d = par_q ^ rx_s_q;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_FULL) begin
            tick_d  = '0;
            state_d = IDLE;
`ifdef UART_PARITY_EN
            perr_d = par_bad_q;
            load_d = rx_s_q && !par_bad_q;
`else
            load_d = rx_s_q;
`endif
            if (!rx_s_q) begin
              ferr_d      = 1'b1;
              need_high_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift      = shift_q;
  assign serial_bit = bit_val_q;
  assign load       = load_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner cases, random frames.
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_rx_ctrl;
  localparam int DW   = 8;
  localparam int OV   = 16;
  localparam int TDIV = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_in;
  logic sample_tick;
  logic shift, serial_bit, load, frame_err, parity_err, busy;

  int total = 0;
  int bad   = 0;

  int          n_shift, n_load, n_ferr, n_perr;
  bit          busy_seen;
  logic [DW-1:0] rx_word;
  logic [DW-1:0] load_q[$];
  int          tick_div = 0;

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         stop;
    int         e_load;
    int         e_ferr;
    int         e_perr;
  } vec_t;
  vec_t vecs[$];

  uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OV)) dut (
    .rx_clk(clk),
    .rx_rst_n(rst_n),
    .rx_in(rx_in),
    .sample_tick(sample_tick),
    .shift(shift),
    .serial_bit(serial_bit),
    .load(load),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div    = (tick_div + 1) % TDIV;
      sample_tick = (tick_div == 0);
    end
  end

  always @(negedge clk) begin
    if (shift) begin
      n_shift++;
      rx_word = {serial_bit, rx_word[DW-1:1]};
    end
    if (load) begin
      n_load++;
      load_q.push_back(rx_word);
      total++;
      if (shift || frame_err) begin
        bad++;
        $display("FAIL load_exclusive: shift=%0b frame_err=%0b with load, required both 0", shift, frame_err);
      end
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, required finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_shift   = 0;
    n_load    = 0;
    n_ferr    = 0;
    n_perr    = 0;
    busy_seen = 1'b0;
    rx_word   = '0;
    load_q.delete();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int n);
    rx_in = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit stop);
    send_bit(1'b0, OV);
    for (int i = 0; i < DW; i++) send_bit(d[i], OV);
`ifdef UART_PARITY_EN
    send_bit(p, OV);
`endif
    send_bit(stop, OV);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit p, input bit stop,
                           input int gap, input int e_load, input int e_ferr, input int e_perr);
    clear_mon();
    send_frame(d, p, stop);
    send_bit(1'b1, gap);
    chk({tag, "_shifts"}, n_shift, DW);
    chk({tag, "_word"}, rx_word, d);
    chk({tag, "_load"}, n_load, e_load);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
    chk({tag, "_perr"}, n_perr, e_perr);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit         p, stop;
    int         gap, e_perr, e_load, waited;

    vecs.push_back('{8'hA5, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b1, 1, 0, 0});
    vecs.push_back('{8'h7E, 1'b0, 1'b0, 0, 1, 0});
`ifdef UART_PARITY_EN
    vecs.push_back('{8'h07, 1'b0, 1'b1, 0, 0, 1});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 0});
`endif

    rst_n = 1'b0;
    rx_in = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_shift", shift, 0);
    chk("rst_load", load, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_serial_bit", serial_bit, 0);
    rst_n = 1'b1;
    send_bit(1'b1, 8);

    for (int i = 0; i < vecs.size(); i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop, 16,
                vecs[i].e_load, vecs[i].e_ferr, vecs[i].e_perr);

    // False start: short low pulse must be rejected.
    clear_mon();
    send_bit(1'b0, 5);
    rx_in  = 1'b1;
    waited = 0;
    while (busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("false_start_busy_seen", busy_seen, 1);
    chk("false_start_busy", busy, 0);
    send_bit(1'b1, 16);
    chk("false_start_shifts", n_shift, 0);
    chk("false_start_load", n_load, 0);
    chk("false_start_ferr", n_ferr, 0);

    // Stop sampled low with the line held low afterwards: no new frame may start.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b0, 48);
    chk("hold_low_shifts", n_shift, DW);
    chk("hold_low_ferr", n_ferr, 1);
    chk("hold_low_load", n_load, 0);
    chk("hold_low_busy", busy, 0);
    send_bit(1'b1, 16);
    run_frame("after_ferr", 8'h01, 1'b1, 1'b1, 16, 1, 0, 0);

    // Reset after the third data bit.
    clear_mon();
    send_bit(1'b0, OV);
    for (int i = 0; i < 3; i++) send_bit(i == 2, OV);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_perr", parity_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_serial_bit", serial_bit, 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 16);
    chk("post_rst_no_load", n_load, 0);
    chk("post_rst_no_ferr", n_ferr, 0);
    run_frame("after_rst", 8'hFF, 1'b0, 1'b1, 16, 1, 0, 0);

    // Back-to-back frames with no gap after the stop bit.
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_bit(1'b1, 16);
    chk("b2b_shifts", n_shift, 2 * DW);
    chk("b2b_loads", n_load, 2);
    chk("b2b_count", load_q.size(), 2);
    if (load_q.size() == 2) begin
      chk("b2b_word0", load_q[0], 8'h55);
      chk("b2b_word1", load_q[1], 8'hAA);
    end

    // Random frames against the frame-level rules.
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      p    = (^d) ^ ($urandom_range(0, 3) == 0);
      gap  = stop ? $urandom_range(0, 24) : $urandom_range(16, 24);
`ifdef UART_PARITY_EN
      e_perr = (p != ^d);
`else
      e_perr = 0;
`endif
      e_load = (stop && e_perr == 0) ? 1 : 0;
      run_frame($sformatf("rnd%0d", i), d, p, stop, gap, e_load, stop ? 0 : 1, e_perr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
